// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the icache (read-only) and dcache (read/write).
// Define DCACHE_PRIORITY_EN for fixed dcache priority; default build is round-robin.
module cache_mem_arbiter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ic_req_i,
    input  logic [WIDTH-1:0] ic_addr_i,
    output logic             ic_done_o,
    input  logic             dc_req_i,
    input  logic             dc_we_i,
    input  logic [WIDTH-1:0] dc_addr_i,
    input  logic [WIDTH-1:0] dc_wdata_i,
    output logic             dc_done_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] mem_address_o,
    output logic [WIDTH-1:0] mem_write_data_o,
    output logic             mem_write_enable_o,
    input  logic [WIDTH-1:0] mem_incoming_data_i
);

    localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q;
    logic               owner_dc_q;
    logic               we_q;
    logic [WIDTH-1:0]   addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               grant_any;
    logic               grant_dc;

`ifdef DCACHE_PRIORITY_EN
    always_comb begin
        grant_any = ic_req_i | dc_req_i;
        grant_dc  = dc_req_i;
    end
`else
    logic last_grant_dc_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = ic_req_i | dc_req_i;
        if (ic_req_i && dc_req_i) begin
            grant_dc = ~last_grant_dc_q;
        end else begin
            grant_dc = dc_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_dc_q <= 1'b0;
        end else if (state_q == StIdle && grant_any) begin
            last_grant_dc_q <= grant_dc;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_any) state_d = StAccess;
            StAccess: if (cnt_q == 4'd0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o             = (state_q != StIdle);
        ic_done_o          = (state_q == StDone) && !owner_dc_q;
        dc_done_o          = (state_q == StDone) && owner_dc_q;
        mem_write_enable_o = (state_q == StAccess) && we_q;
        mem_address_o      = addr_q;
        mem_write_data_o   = wdata_q;
        rdata_o            = rdata_q;
    end

    // Access registers are frozen at grant so requester input changes cannot disturb memory.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= 4'd0;
            owner_dc_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        owner_dc_q <= grant_dc;
                        addr_q     <= grant_dc ? dc_addr_i : ic_addr_i;
                        we_q       <= grant_dc & dc_we_i;
                        cnt_q      <= CntInit;
                        if (grant_dc && dc_we_i) begin
                            wdata_q <= dc_wdata_i;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!we_q) begin
                        rdata_q <= mem_incoming_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table plus scoreboard of expected accesses.
module tb_cache_mem_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned L = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req = 1'b0;
    logic [W-1:0] ic_addr = '0;
    logic         ic_done;
    logic         dc_req = 1'b0;
    logic         dc_we = 1'b0;
    logic [W-1:0] dc_addr = '0;
    logic [W-1:0] dc_wdata = '0;
    logic         dc_done;
    logic [W-1:0] rdata;
    logic         busy;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_we;
    logic [W-1:0] mem_rdata;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.WIDTH(W), .MEM_LATENCY(L)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .ic_req_i            (ic_req),
        .ic_addr_i           (ic_addr),
        .ic_done_o           (ic_done),
        .dc_req_i            (dc_req),
        .dc_we_i             (dc_we),
        .dc_addr_i           (dc_addr),
        .dc_wdata_i          (dc_wdata),
        .dc_done_o           (dc_done),
        .rdata_o             (rdata),
        .busy_o              (busy),
        .mem_address_o       (mem_addr),
        .mem_write_data_o    (mem_wdata),
        .mem_write_enable_o  (mem_we),
        .mem_incoming_data_i (mem_rdata)
    );

    function automatic logic [W-1:0] mem_model(input logic [W-1:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    typedef struct {
        logic         dc;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[5];
    vec_t e;
    vec_t v;
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    int   we_cnt = 0;
    int   cyc;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        if (t.dc) begin
            dc_req   = 1'b1;
            dc_we    = t.we;
            dc_addr  = t.addr;
            dc_wdata = t.wdata;
        end else begin
            ic_req  = 1'b1;
            ic_addr = t.addr;
        end
        sb.push_back(t);
    endtask

    // Returns the number of rising edges until a done pulse is seen; -1 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ic_done || dc_done) return;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout actual=no_done required=done t=%0t", $time);
        n = -1;
    endtask

    initial begin
        vecs[0] = '{dc: 1'b0, we: 1'b0, addr: 32'h40,  wdata: 32'h0,         rdata: 32'hDEAD_BEEF};
        vecs[1] = '{dc: 1'b1, we: 1'b1, addr: 32'h80,  wdata: 32'h1234_5678, rdata: 32'hDEAD_BEEF};
        vecs[2] = '{dc: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0,         rdata: 32'h0100_FEFF};
        vecs[3] = '{dc: 1'b0, we: 1'b0, addr: 32'h8,   wdata: 32'h0,         rdata: 32'h0008_FFF7};
        vecs[4] = '{dc: 1'b1, we: 1'b1, addr: 32'h104, wdata: 32'hA5A5_5A5A, rdata: 32'h0008_FFF7};

        // Scoreboard monitor: per-cycle invariants, then per-access checks on each done pulse.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    busy_cnt = 0;
                    we_cnt   = 0;
                end else begin
                    chk("both_done", 32'(ic_done & dc_done), 32'h0);
                    chk("we_when_idle", 32'(mem_we & ~busy), 32'h0);
                    if (busy) begin
                        busy_cnt++;
                        if (mem_we) we_cnt++;
                        if (sb.size() > 0) begin
                            chk("mem_addr", mem_addr, sb[0].addr);
                            if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
                        end
                    end
                    if (ic_done || dc_done) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_done actual=ic%0b_dc%0b required=none t=%0t",
                                     ic_done, dc_done, $time);
                        end else begin
                            e = sb.pop_front();
                            chk("done_owner_dc", 32'(dc_done), 32'(e.dc));
                            chk("done_owner_ic", 32'(ic_done), 32'(!e.dc));
                            chk("rdata", rdata, e.rdata);
                            chk("busy_cycles", 32'(busy_cnt), 32'(L + 1));
                            chk("we_cycles", 32'(we_cnt), e.we ? 32'(L) : 32'h0);
                            chk("we_in_done", 32'(mem_we), 32'h0);
                        end
                        busy_cnt = 0;
                        we_cnt   = 0;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ic_done", 32'(ic_done), 32'h0);
        chk("rst_dc_done", 32'(dc_done), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i]);
            wait_done(cyc);
            chk("latency", 32'(cyc), 32'(L + 1));
            ic_req = 1'b0;
            dc_req = 1'b0;
            @(negedge clk);
            chk("done_width", 32'(ic_done | dc_done), 32'h0);
        end

        // Back-to-back icache reads with request held through done.
        v = '{dc: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0000_FFFF};
        drive(v);
        wait_done(cyc);
        ic_addr = 32'h4;
        sb.push_back('{dc: 1'b0, we: 1'b0, addr: 32'h4, wdata: 32'h0, rdata: 32'h0004_FFFB});
        wait_done(cyc);
        chk("b2b_spacing", 32'(cyc), 32'(L + 2));
        ic_req = 1'b0;
        @(negedge clk);

        // Address change after grant must not reach memory.
        v = '{dc: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0, rdata: 32'h0100_FEFF};
        drive(v);
        @(posedge clk);
        @(negedge clk);
        dc_addr = 32'h200;
        wait_done(cyc);
        chk("held_addr", mem_addr, 32'h100);
        dc_req = 1'b0;
        @(negedge clk);

        // Reset during the second ACCESS cycle of a write.
        v = '{dc: 1'b1, we: 1'b1, addr: 32'h300, wdata: 32'hCAFE_F00D, rdata: 32'h0};
        drive(v);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("we_access2", 32'(mem_we), 32'h1);
        #1 rst = 1'b1;
        dc_req = 1'b0;
        @(negedge clk);
        chk("midrst_we", 32'(mem_we), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(ic_done | dc_done), 32'h0);
        sb.delete();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        v = '{dc: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h0, rdata: 32'hDEAD_BEEF};
        drive(v);
        wait_done(cyc);
        chk("post_rst_latency", 32'(cyc), 32'(L + 1));
        ic_req = 1'b0;
        @(negedge clk);

        // Both requests held from reset: arbitration order over four accesses.
        #1 rst = 1'b1;
        ic_addr = 32'h10;
        dc_addr = 32'h20;
        dc_we   = 1'b0;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef DCACHE_PRIORITY_EN
            sb.push_back('{dc: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0, rdata: 32'h0020_FFDF});
`else
            if (i % 2 == 0) begin
                sb.push_back('{dc: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0,
                               rdata: 32'h0020_FFDF});
            end else begin
                sb.push_back('{dc: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,
                               rdata: 32'h0010_FFEF});
            end
`endif
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc);
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
